// File: rtl/mac_pkg.sv
// Shared widths and operand types for the 9-tap MAC and its window feeder.
package mac_pkg;
   localparam int DW      = 9;
   localparam int N_TAPS  = 9;
   localparam int ACC_W   = 24;
   localparam int MAC_LAT = 5;

   typedef logic [N_TAPS-1:0][DW-1:0] mac_vec_t;

   // One new window column: top = two rows back, bot = incoming sample.
   typedef struct packed {
      logic [DW-1:0] top;
      logic [DW-1:0] mid;
      logic [DW-1:0] bot;
   } win_col_t;
endpackage

// File: rtl/result_fifo.sv
// Synchronous result FIFO, zero-latency head; push+pop legal at any occupancy.
// Head reads as zero when empty; sticky overflow flag on a push into a full FIFO without a pop.
module result_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 24,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dat_o,
   output logic             vld_o,
   output logic [CW-1:0]    cnt_o,
   output logic             err_ovf_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             empty, full, push_ok, pop_ok;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign pop_ok  = pop_i && !empty;
   assign push_ok = push_i && (!full || pop_ok);

   always_comb begin
      wr_d  = push_ok ? ptr_inc(wr_q) : wr_q;
      rd_d  = pop_ok ? ptr_inc(rd_q) : rd_q;
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
      ovf_d = ovf_q | (push_i & full & ~pop_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= push_dat_i;
   end

   assign dat_o     = empty ? '0 : mem_q[rd_q];
   assign vld_o     = !empty;
   assign cnt_o     = cnt_q;
   assign err_ovf_o = ovf_q;
endmodule

// File: rtl/mac_window_feeder.sv
// Raster stream -> 3x3 valid-region windows for the MAC, results captured after MAC_LAT and queued.
// Adds 6 cycles accept-to-m_valid; s_ready is withheld at window positions when FIFO+in-flight is full.
module mac_window_feeder
   import mac_pkg::*;
#(
   parameter int IMG_W   = 16,
   parameter int IMG_H   = 16,
   parameter int FIFO_D  = 8,
   parameter int MAC_LAT = mac_pkg::MAC_LAT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [DW-1:0]    s_data,
   input  logic             s_sof,
   output mac_vec_t         win_data,
   output logic             win_valid,
   input  logic [ACC_W-1:0] res_in,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [ACC_W-1:0] m_data,
   output logic             err_ovf
);
   localparam int CW  = $clog2(IMG_W);
   localparam int RW  = $clog2(IMG_H);
   localparam int FCW = $clog2(FIFO_D + 1);
   localparam logic [FCW:0] CREDITS = (FCW + 1)'(FIFO_D);

   logic [CW-1:0]      col_q, col_d, eff_col;
   logic [RW-1:0]      row_q, row_d, eff_row;
   logic [FCW-1:0]     inflight_q, inflight_d, fifo_cnt;
   logic [MAC_LAT-1:0] vpipe_q;
   mac_vec_t           win_q, win_d;
   logic               wv_q;
   logic [DW-1:0]      lb0_q [IMG_W];
   logic [DW-1:0]      lb1_q [IMG_W];
   win_col_t           new_col;
   logic               accept, next_is_win, at_win, credit_ok, issue, push;

   // Credit is judged on the counter position alone, so s_sof can only make it conservative.
   assign next_is_win = (row_q >= RW'(2)) && (col_q >= CW'(2));
   assign credit_ok   = ({1'b0, fifo_cnt} + {1'b0, inflight_q}) < CREDITS;
   assign s_ready     = !next_is_win || credit_ok;
   assign accept      = s_valid && s_ready;

   assign eff_col = s_sof ? '0 : col_q;
   assign eff_row = s_sof ? '0 : row_q;
   assign at_win  = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
   assign issue   = accept && at_win;
   assign push    = vpipe_q[MAC_LAT-1];
   assign new_col = '{top: lb0_q[eff_col], mid: lb1_q[eff_col], bot: s_data};

   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      win_d      = win_q;
      inflight_d = inflight_q + FCW'(issue) - FCW'(push);
      if (accept) begin
         if (eff_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + 1'b1;
         end else begin
            col_d = eff_col + 1'b1;
            row_d = eff_row;
         end
         for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
         end
         win_d[2] = new_col.top;
         win_d[5] = new_col.mid;
         win_d[8] = new_col.bot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q      <= '0;
         row_q      <= '0;
         inflight_q <= '0;
         vpipe_q    <= '0;
         win_q      <= '0;
         wv_q       <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         inflight_q <= inflight_d;
         vpipe_q    <= {vpipe_q[MAC_LAT-2:0], wv_q};
         win_q      <= win_d;
         wv_q       <= issue;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_q[eff_col] <= lb1_q[eff_col];
         lb1_q[eff_col] <= s_data;
      end
   end

   assign win_data  = win_q;
   assign win_valid = wv_q;

   result_fifo #(
      .DEPTH (FIFO_D),
      .WIDTH (ACC_W)
   ) u_result_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push),
      .push_dat_i (res_in),
      .pop_i      (m_ready),
      .dat_o      (m_data),
      .vld_o      (m_valid),
      .cnt_o      (fifo_cnt),
      .err_ovf_o  (err_ovf)
   );
endmodule

// File: tb/tb_mac_window_feeder.sv
// Bench for mac_window_feeder on a 4x4 image with a behavioural 5-cycle MAC (B = all ones).
module tb_mac_window_feeder;
   import mac_pkg::*;
   localparam int W = 4, H = 4, FD = 8, LAT = 5;

   logic clk = 1'b0, rst_n = 1'b0;
   logic s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b0;
   logic [8:0] s_data = '0;
   logic s_ready, win_valid, m_valid, err_ovf;
   mac_vec_t win_data;
   logic [23:0] res_in, m_data;
   logic [23:0] mac_pipe [LAT] = '{default: '0};

   logic f_push = 1'b0, f_pop = 1'b0;
   logic [23:0] f_dat = '0, f_dout;
   logic f_vld, f_ovf;
   logic [2:0] f_cnt;

   int n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   mac_window_feeder #(.IMG_W(W), .IMG_H(H), .FIFO_D(FD), .MAC_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_sof(s_sof), .win_data(win_data), .win_valid(win_valid), .res_in(res_in),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_ovf(err_ovf));

   result_fifo #(.DEPTH(4), .WIDTH(24)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(f_push), .push_dat_i(f_dat), .pop_i(f_pop),
      .dat_o(f_dout), .vld_o(f_vld), .cnt_o(f_cnt), .err_ovf_o(f_ovf));

   function automatic int win_sum(input mac_vec_t v);
      int s = 0;
      for (int k = 0; k < 9; k++) s += int'(v[k]);
      return s;
   endfunction

   // MAC stand-in: computes on whatever sits on A every cycle, result after LAT edges.
   always @(posedge clk) begin
      mac_pipe[0] <= 24'(win_sum(win_data));
      for (int i = 1; i < LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
   end
   assign res_in = mac_pipe[LAT-1];

   // Reference model: frame stored by pixel index, windows summed directly from it.
   int idx = 0;
   int px [W*H];
   int expq[$];
   int got[$];
   int issued = 0, popped = 0, wv_count = 0, cyc = 0;
   int first_mv = -1, first_win = -1;
   bit pend_wv = 0, last_acc = 0, prev_hold = 0;
   logic [80:0] pend_win;
   logic [23:0] prev_data;
   int ramp_exp [4] = '{45, 54, 81, 90};

   task automatic check(input string tag, input logic [80:0] obs, input logic [80:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_ready();
      int r, c;
      r = idx / W;
      c = idx % W;
      return !(r >= 2 && c >= 2) || ((issued - popped) < FD);
   endfunction

   task automatic accept_model(input int d, input bit sof);
      int r, c, s, v;
      if (sof) idx = 0;
      r = idx / W;
      c = idx % W;
      px[idx] = d;
      if (r >= 2 && c >= 2) begin
         s = 0;
         for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++) begin
               v = px[(r - 2 + rr) * W + (c - 2 + cc)];
               s += v;
               pend_win[(3*rr+cc)*9 +: 9] = 9'(v);
            end
         expq.push_back(s);
         issued++;
         pend_wv = 1;
         if (first_win < 0) first_win = cyc;
      end
      idx = (idx + 1) % (W * H);
   endtask

   task automatic model_reset();
      idx = 0;
      expq.delete();
      got.delete();
      issued = 0;
      popped = 0;
      pend_wv = 0;
      prev_hold = 0;
   endtask

   // One clock: observe at the falling edge, return just after the rising edge.
   task automatic cycle();
      int e;
      @(negedge clk);
      cyc++;
      check("win_valid", win_valid, pend_wv);
      if (pend_wv) check("win_data", win_data, pend_win);
      pend_wv = 0;
      if (win_valid) wv_count++;
      check("err_ovf", err_ovf, 1'b0);
      check("s_ready", s_ready, exp_ready());
      if (prev_hold && m_valid) check("m_data_hold", m_data, prev_data);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (m_valid && m_ready) begin
         if (expq.size() == 0) check("spurious_result", m_valid, 1'b0);
         else begin
            e = expq.pop_front();
            check("result", m_data, e);
            got.push_back(int'(m_data));
            popped++;
         end
      end
      last_acc = s_valid && s_ready;
      if (last_acc) accept_model(int'(s_data), s_sof);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic send(input int d, input bit sof, input int budget, output bit ok);
      s_valid = 1'b1;
      s_data  = 9'(d);
      s_sof   = sof;
      ok      = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         cycle();
         ok = last_acc;
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic send_ramp(input string tag, input int n);
      bit ok;
      for (int i = 0; i < n; i++) begin
         send(i, i == 0, 20, ok);
         check(tag, ok, 1'b1);
      end
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (expq.size() != 0 || pend_wv); i++) cycle();
      check("drain_empty", expq.size(), 0);
   endtask

   task automatic check_ramp(input string tag);
      check({tag, "_count"}, got.size(), 4);
      for (int k = 0; k < 4; k++)
         check({tag, "_value"}, (k < got.size()) ? got[k] : -1, ramp_exp[k]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, s_ready, 1'b1);
      check({tag, "_win_valid"}, win_valid, 1'b0);
      check({tag, "_win_data"}, win_data, '0);
      check({tag, "_m_valid"}, m_valid, 1'b0);
      check({tag, "_m_data"}, m_data, '0);
      check({tag, "_err_ovf"}, err_ovf, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int stall_at;
      int d3 [48];

      #1;
      check_reset_outputs("reset");
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // Single ramp frame; sample 10 is the first window, m_valid seen 7 falling edges later (= edge e+6).
      m_ready = 1'b1;
      first_mv = -1;
      first_win = -1;
      got.delete();
      send_ramp("s1_accept", 16);
      drain(60);
      check_ramp("s1");
      check("s1_latency", first_mv - first_win, 7);

      // Isolated random beats with random gaps.
      got.delete();
      wv_count = 0;
      for (int i = 0; i < 16; i++) begin
         send($urandom_range(0, 511), i == 0, 20, ok);
         check("s2_accept", ok, 1'b1);
         idle($urandom_range(1, 6));
      end
      drain(60);
      check("s2_win_pulses", wv_count, 4);
      check("s2_count", got.size(), 4);

      // Three frames back to back with the sink stalled: the 9th window position must block.
      got.delete();
      m_ready = 1'b0;
      stall_at = -1;
      for (int i = 0; i < 48; i++) d3[i] = $urandom_range(0, 511);
      for (int i = 0; i < 48; i++) begin
         send(d3[i], (i % 16) == 0, 40, ok);
         if (!ok) begin
            stall_at = i;
            check("s3_s_ready_low", s_ready, 1'b0);
            check("s3_fifo_full_valid", m_valid, 1'b1);
            m_ready = 1'b1;
            send(d3[i], (i % 16) == 0, 40, ok);
         end
         check("s3_accept", ok, 1'b1);
      end
      drain(100);
      check("s3_stall_at", stall_at, 42);
      check("s3_count", got.size(), 12);

      // SOF at sample 6 restarts the frame.
      got.delete();
      send_ramp("s4_pre", 6);
      send_ramp("s4_accept", 16);
      drain(60);
      check_ramp("s4");

      // Reset with three windows in flight, then a clean frame.
      send_ramp("s5_pre", 15);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("s5_reset");
      model_reset();
      idle(2);
      rst_n = 1'b1;
      idle(10);
      check("s5_no_stale", m_valid, 1'b0);
      send_ramp("s5_accept", 16);
      drain(60);
      check_ramp("s5");

      // Result FIFO corner: push and pop together while full, then overflow attempt.
      f_push = 1'b1;
      for (int v = 1; v <= 4; v++) begin
         f_dat = 24'(v * 10);
         cycle();
      end
      f_push = 1'b0;
      check("fifo_full_cnt", f_cnt, 3'd4);
      check("fifo_full_head", f_dout, 24'd10);
      f_push = 1'b1;
      f_pop  = 1'b1;
      f_dat  = 24'd50;
      cycle();
      f_push = 1'b0;
      f_pop  = 1'b0;
      check("fifo_pushpop_cnt", f_cnt, 3'd4);
      check("fifo_pushpop_head", f_dout, 24'd20);
      check("fifo_pushpop_ovf", f_ovf, 1'b0);
      f_push = 1'b1;
      f_dat  = 24'd99;
      cycle();
      f_push = 1'b0;
      check("fifo_ovf_set", f_ovf, 1'b1);
      check("fifo_ovf_cnt", f_cnt, 3'd4);
      f_pop = 1'b1;
      for (int v = 2; v <= 5; v++) begin
         check("fifo_drain", f_dout, 24'(v * 10));
         cycle();
      end
      f_pop = 1'b0;
      check("fifo_empty_cnt", f_cnt, 3'd0);
      check("fifo_empty_vld", f_vld, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
